// File: rtl/u_dec_pipe.sv
// u_dec_pipe: a pipelined, flow-controlled thermometer-code decoder.
//
// It accepts candidate vectors on a valid/ready input and sorts each one into
// one of three classes:
//   - standard code: a run of ones at the LSB end with zeros above it;
//   - complemented code: a run of zeros at the LSB end with ones above it;
//   - invalid.
// For every vector it reports the binary run length, a polarity flag and an
// error flag. It also keeps a saturating count of the error results that have
// been consumed downstream.
//
// Pipeline:
//   S1 registers the raw vector. The classification is computed from that
//     register.
//   S2 registers the encoded result, which drives the outputs.
//
// Ports:
//   i_clk      rising-edge clock for all state
//   i_arst     asynchronous active-high reset
//   i_valid    upstream vector valid
//   o_ready    block can accept a vector this cycle (combinational on i_ready)
//   i_x        candidate vector, W bits
//   o_valid    decoded result valid
//   i_ready    downstream accepts the result
//   o_count    run length, CW bits
//   o_neg      1 = complemented code
//   o_err      1 = vector was not admissible
//   i_clr_err  synchronous clear of the error counter (wins over increment)
//   o_err_cnt  saturating count of error results transferred downstream
module u_dec_pipe #(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter int ERR_CNT_W             = 8,
  localparam int CW                   = $clog2(W)
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W-1:0]         i_x,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CW-1:0]        o_count,
  output logic                 o_neg,
  output logic                 o_err,
  input  logic                 i_clr_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  // A vector of the form 2^k-1 (ones only at the LSB end) satisfies v & (v+1) == 0.
  // The all-ones vector also passes this test, because v+1 wraps to zero.
  function automatic logic is_therm(input logic [W-1:0] v);
    return (v & (v + W'(1))) == '0;
  endfunction

  function automatic logic [CW-1:0] pop_count(input logic [W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) n++;
    end
    return CW'(n);
  endfunction

  logic          s1_valid;
  logic [W-1:0]  s1_x;
  logic          s2_can_load;

  logic          std_match;
  logic          cmp_match;
  logic [CW-1:0] cls_count;
  logic          cls_neg;
  logic          cls_err;

  // A stage may load when it is empty or when its contents leave in the same cycle.
  assign s2_can_load = !o_valid || i_ready;
  assign o_ready     = !s1_valid || s2_can_load;

  // S1: capture the raw vector. i_x is not sampled when i_valid is low.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) s1_x <= i_x;
    end
  end

  // Classification.
  // All-ones is excluded from the standard code. It then decodes as a
  // complemented code with a zero run length when that code is admitted,
  // and as an error otherwise.
  // All-zeros is excluded from the complemented code, so that the two
  // classes never overlap.
  // For a complemented code, the number of LSB zeros equals the number of
  // ones in the inverted vector.
  always_comb begin
    std_match = is_therm(s1_x) && (s1_x != '1);
    cmp_match = P_ADMIT_COMPLIMENT_EN && is_therm(~s1_x) && (s1_x != '0);
    cls_count = '0;
    cls_neg   = 1'b0;
    cls_err   = 1'b0;
    if (std_match) begin
      cls_count = pop_count(s1_x);
    end else if (cmp_match) begin
      cls_count = pop_count(~s1_x);
      cls_neg   = 1'b1;
    end else begin
      cls_err   = 1'b1;
    end
  end

  // S2: hold the encoded result. While stalled, nothing reloads, so the
  // outputs stay stable.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_valid <= 1'b0;
      o_count <= '0;
      o_neg   <= 1'b0;
      o_err   <= 1'b0;
    end else if (s2_can_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_count <= cls_count;
        o_neg   <= cls_neg;
        o_err   <= cls_err;
      end
    end
  end

  // Error counter.
  // It counts only error results that are actually handed downstream, and it
  // saturates rather than wrapping. A clear in the same cycle takes priority.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_err_cnt <= '0;
    end else if (i_clr_err) begin
      o_err_cnt <= '0;
    end else if (o_valid && i_ready && o_err && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
